// File: rtl/binary_to_gray_conv_if.sv
// Bus bundle for binary_to_gray_conv: input qualifier, mode, data and registered result.
// Optional parity output is present when BTG_OUT_PARITY_EN is defined.
interface binary_to_gray_conv_if #(
    parameter int unsigned N = 4
);
    logic         in_valid;
    logic         mode;
    logic [N-1:0] binary_in;
    logic [N-1:0] gray_out;
    logic         out_valid;
`ifdef BTG_OUT_PARITY_EN
    logic         out_parity;

    // Producer side: drives the request, observes the result
    modport master (
        output in_valid, mode, binary_in,
        input  gray_out, out_valid, out_parity
    );

    // Converter side
    modport slave (
        input  in_valid, mode, binary_in,
        output gray_out, out_valid, out_parity
    );
`else
    // Producer side: drives the request, observes the result
    modport master (
        output in_valid, mode, binary_in,
        input  gray_out, out_valid
    );

    // Converter side
    modport slave (
        input  in_valid, mode, binary_in,
        output gray_out, out_valid
    );
`endif
endinterface

// File: rtl/binary_to_gray_conv.sv
// Registered binary<->Gray converter with a 1-cycle latency and a valid qualifier.
// mode=0: binary to reflected Gray; mode=1: Gray to binary (prefix XOR from MSB).
// Optional feature macro: BTG_OUT_PARITY_EN adds a registered XOR-reduction of the result.
module binary_to_gray_conv #(
    parameter int unsigned N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    binary_to_gray_conv_if.slave  bus
);
    localparam int unsigned W = N;

    logic [W-1:0] conv_c;

    // Conversion datapath for the currently presented input
    always_comb begin
        conv_c = '0;
        if (!bus.mode) begin
            conv_c = bus.binary_in ^ (bus.binary_in >> 1);
        end else begin
            // Bit i of the binary value is the XOR of Gray bits i..W-1
            for (int unsigned i = 0; i < W; i++) begin
                conv_c[i] = ^(bus.binary_in >> i);
            end
        end
    end

    // Output register: capture on valid, hold on idle, drop valid on idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.gray_out  <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.gray_out <= conv_c;
            end
        end
    end

`ifdef BTG_OUT_PARITY_EN
    // Parity of the captured result, same timing and hold as gray_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_parity <= 1'b0;
        end else if (bus.in_valid) begin
            bus.out_parity <= ^conv_c;
        end
    end
`endif

endmodule

// File: tb/tb_binary_to_gray_conv.sv
// Directed testbench for binary_to_gray_conv (N=4).
module tb_binary_to_gray_conv;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    logic [3:0] gray_tab [16];
    logic [3:0] prev_gray;

    binary_to_gray_conv_if #(.N(4)) bus ();

    binary_to_gray_conv #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present inputs, then advance past the next rising edge
    task automatic step(input logic v, input logic m, input logic [3:0] d);
        bus.in_valid  = v;
        bus.mode      = m;
        bus.binary_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        gray_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.binary_in = 4'h0;

        // Reset state
        #12;
        chk("rst_gray", 32'(bus.gray_out), 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Accept 1111 -> 1000
        step(1'b1, 1'b0, 4'hF);
        chk("pre_rst_gray", 32'(bus.gray_out), 32'h8);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'h1);

        // Asynchronous reset mid-cycle with in_valid still high
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gray", 32'(bus.gray_out), 32'h0);
        chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("post_rst_gray", 32'(bus.gray_out), 32'h0);

        // Forward sweep with adjacency check, including 15 -> 0 wrap
        for (int b = 0; b < 16; b++) begin
            step(1'b1, 1'b0, 4'(b));
            chk($sformatf("fwd_%0d", b), 32'(bus.gray_out), 32'(gray_tab[b]));
            chk($sformatf("fwd_valid_%0d", b), 32'(bus.out_valid), 32'h1);
`ifdef BTG_OUT_PARITY_EN
            chk($sformatf("parity_%0d", b), 32'(bus.out_parity), 32'(^gray_tab[b]));
`endif
            if (b > 0) begin
                chk($sformatf("hamming_%0d", b), 32'($countones(prev_gray ^ bus.gray_out)), 32'h1);
            end
            prev_gray = bus.gray_out;
        end
        step(1'b1, 1'b0, 4'h0);
        chk("wrap_gray", 32'(bus.gray_out), 32'h0);
        chk("wrap_hamming", 32'($countones(prev_gray ^ bus.gray_out)), 32'h1);

        // Inverse sweep: Gray codes back to 0..15
        for (int b = 0; b < 16; b++) begin
            step(1'b1, 1'b1, gray_tab[b]);
            chk($sformatf("inv_%0d", b), 32'(bus.gray_out), 32'(b));
        end

        // Round trip 1011 -> 1110 -> 1011
        step(1'b1, 1'b0, 4'b1011);
        chk("rt_fwd", 32'(bus.gray_out), 32'hE);
        step(1'b1, 1'b1, 4'b1110);
        chk("rt_inv", 32'(bus.gray_out), 32'hB);

        // Idle hold with changing data
        step(1'b1, 1'b0, 4'b0110);
        chk("hold_load", 32'(bus.gray_out), 32'h5);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'($urandom_range(1)), 4'($urandom_range(15)));
            chk($sformatf("hold_gray_%0d", k), 32'(bus.gray_out), 32'h5);
            chk($sformatf("hold_valid_%0d", k), 32'(bus.out_valid), 32'h0);
`ifdef BTG_OUT_PARITY_EN
            chk($sformatf("hold_parity_%0d", k), 32'(bus.out_parity), 32'h0);
`endif
        end
        step(1'b0, 1'b0, 4'bxxxx);
        chk("hold_x_gray", 32'(bus.gray_out), 32'h5);

        // Back-to-back mode toggle
        step(1'b1, 1'b0, 4'b0101);
        chk("toggle_a", 32'(bus.gray_out), 32'h7);
        step(1'b1, 1'b1, 4'b0101);
        chk("toggle_b", 32'(bus.gray_out), 32'h6);
        chk("toggle_valid", 32'(bus.out_valid), 32'h1);
        step(1'b0, 1'b0, 4'h0);
        chk("final_valid", 32'(bus.out_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
